frame_seq_ctrl: RTL and testbench

Top-level sequencer for the picture frame. It brings up the SD and LCD SPI interfaces, then streams one picture of `BLK_PER_PIC` 512-byte SD blocks into the ILI9341 frame memory. It then parks until the UART control block requests the next or previous picture. It sits between `d_pic_f`'s UART control port and the SD/LCD interface blocks, and it only issues commands: no pixel data passes through it.

---
 rtl/dpf_pkg.sv | 39 +++
 rtl/cmd_tracker.sv | 53 +++++
 rtl/frame_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpf_pkg.sv
// Shared types and constants for the picture-frame sequencer: one-hot states,
// SD/LCD command codes and default geometry.
package dpf_pkg;

   localparam int unsigned StateW       = 7;
   localparam int unsigned DefBlkPerPic = 300;
   localparam int unsigned DefNPic      = 16;

   typedef enum logic [StateW-1:0] {
      StInit     = 7'b000_0001,
      StOfsRst   = 7'b000_0010,
      StBlkStart = 7'b000_0100,
      StStream   = 7'b000_1000,
      StCrc      = 7'b001_0000,
      StWaitUart = 7'b010_0000,
      StIdxMod   = 7'b100_0000
   } state_e;

   typedef enum logic [1:0] {
      SdInit   = 2'd0,
      SdBlkRd  = 2'd1,
      SdStream = 2'd2,
      SdCrc    = 2'd3
   } sd_cmd_e;

   typedef enum logic [1:0] {
      LcdInit   = 2'd0,
      LcdWin    = 2'd1,
      LcdStream = 2'd2
   } lcd_cmd_e;

   // First block of the last picture; evaluated only at elaboration.
   function automatic logic [31:0] last_pic_blk(input logic [31:0] base,
                                                input int unsigned blk_per_pic,
                                                input int unsigned n_pic);
      return base + 32'(blk_per_pic * (n_pic - 1));
   endfunction

endpackage

// File: rtl/cmd_tracker.sv
// Issues a one-cycle command pulse and tracks completion of one peripheral:
// ignores busy on the cycle after issue, then the first non-busy cycle completes.
module cmd_tracker
   import dpf_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_skip,
   input  logic i_busy,
   output logic o_cmd_valid,
   output logic o_done
);

   logic r_valid;
   logic r_ignore;
   logic r_sample;
   logic r_done;
   logic w_hit;

   assign w_hit = r_sample & ~i_busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid  <= 1'b0;
         r_ignore <= 1'b0;
         r_sample <= 1'b0;
         r_done   <= 1'b0;
      end else if (i_start) begin
         // A skipped peripheral is complete from the first cycle of the state.
         r_valid  <= ~i_skip;
         r_ignore <= 1'b0;
         r_sample <= 1'b0;
         r_done   <= i_skip;
      end else begin
         r_valid  <= 1'b0;
         r_ignore <= r_valid;
         if (r_ignore) begin
            r_sample <= 1'b1;
         end else if (w_hit) begin
            r_sample <= 1'b0;
         end
         if (w_hit) begin
            r_done <= 1'b1;
         end
      end
   end

   assign o_cmd_valid = r_valid;
   // Done is visible in the sampling cycle so the state can exit on that edge.
   assign o_done      = r_done | w_hit;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Picture-frame top sequencer: brings up SD and LCD, streams one picture block by
// block into the LCD, then waits for UART next/previous requests.
module frame_seq_ctrl
   import dpf_pkg::*;
#(
   parameter int unsigned BLK_PER_PIC = DefBlkPerPic,
   parameter int unsigned N_PIC       = DefNPic,
   parameter logic [31:0] BASE_BLK    = 32'd0,
   localparam int unsigned IdxW       = (N_PIC > 1) ? $clog2(N_PIC) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic              o_sd_cmd_valid,
   output logic [1:0]        o_sd_cmd,
   output logic [31:0]       o_sd_blk_addr,
   input  logic              i_sd_busy,
   output logic              o_lcd_cmd_valid,
   output logic [1:0]        o_lcd_cmd,
   input  logic              i_lcd_busy,
   output logic              o_stream_en,
   input  logic              i_uart_incr,
   input  logic              i_uart_decr,
   output logic              o_uart_ack,
   output logic [IdxW-1:0]   o_pic_idx,
   output logic [StateW-1:0] o_state_dbg
);

   localparam logic [31:0] LastBlk = last_pic_blk(BASE_BLK, BLK_PER_PIC, N_PIC);

   state_e          r_state;
   logic            r_boot;
   sd_cmd_e         r_sd_cmd;
   lcd_cmd_e        r_lcd_cmd;
   logic [31:0]     r_sd_blk_addr;
   logic            r_stream_en;
   logic            r_uart_ack;
   logic [IdxW-1:0] r_pic_idx;
   logic [31:0]     r_blk_id;
   logic [8:0]      r_blk_offset;
   logic            r_req_incr;
   logic            r_req_decr;

   state_e      w_state_d;
   logic        w_sd_start;
   sd_cmd_e     w_sd_code;
   logic        w_lcd_start;
   logic        w_lcd_skip;
   lcd_cmd_e    w_lcd_code;
   logic        w_sd_done;
   logic        w_lcd_done;
   logic        w_both_done;
   logic [9:0]  w_off_inc;
   logic [8:0]  w_addr_off;
   logic [31:0] w_blk_addr;
   logic        w_req;

   cmd_tracker u_sd_trk (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (w_sd_start),
      .i_skip      (1'b0),
      .i_busy      (i_sd_busy),
      .o_cmd_valid (o_sd_cmd_valid),
      .o_done      (w_sd_done)
   );

   cmd_tracker u_lcd_trk (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (w_lcd_start),
      .i_skip      (w_lcd_skip),
      .i_busy      (i_lcd_busy),
      .o_cmd_valid (o_lcd_cmd_valid),
      .o_done      (w_lcd_done)
   );

   assign w_both_done = w_sd_done & w_lcd_done;
   assign w_off_inc   = {1'b0, r_blk_offset} + 10'd1;
   assign w_req       = i_uart_incr | i_uart_decr;
   assign w_blk_addr  = r_blk_id + 32'(w_addr_off);

   // Commands are launched on the edge that enters the state that owns them.
   always_comb begin
      w_state_d   = r_state;
      w_sd_start  = 1'b0;
      w_sd_code   = SdInit;
      w_lcd_start = 1'b0;
      w_lcd_skip  = 1'b0;
      w_lcd_code  = LcdInit;
      w_addr_off  = '0;
      unique case (r_state)
         StInit: begin
            if (r_boot) begin
               w_sd_start  = 1'b1;
               w_lcd_start = 1'b1;
            end else if (w_both_done) begin
               w_state_d = StOfsRst;
            end
         end
         StOfsRst: begin
            w_state_d   = StBlkStart;
            w_sd_start  = 1'b1;
            w_sd_code   = SdBlkRd;
            w_lcd_start = 1'b1;
            w_lcd_code  = LcdWin;
         end
         StBlkStart: begin
            if (w_both_done) begin
               w_state_d   = StStream;
               w_sd_start  = 1'b1;
               w_sd_code   = SdStream;
               w_lcd_start = 1'b1;
               w_lcd_code  = LcdStream;
            end
         end
         StStream: begin
            if (w_both_done) begin
               w_state_d   = StCrc;
               w_sd_start  = 1'b1;
               w_sd_code   = SdCrc;
               w_lcd_start = 1'b1;
               w_lcd_skip  = 1'b1;
            end
         end
         StCrc: begin
            if (w_both_done) begin
               if (32'(w_off_inc) < BLK_PER_PIC) begin
                  w_state_d   = StBlkStart;
                  w_sd_start  = 1'b1;
                  w_sd_code   = SdBlkRd;
                  w_addr_off  = w_off_inc[8:0];
                  w_lcd_start = 1'b1;
                  w_lcd_skip  = 1'b1;
               end else begin
                  w_state_d = StWaitUart;
               end
            end
         end
         StWaitUart: begin
            if (w_req) begin
               w_state_d = StIdxMod;
            end
         end
         StIdxMod: w_state_d = StOfsRst;
         default:  w_state_d = StInit;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StInit;
         r_boot        <= 1'b1;
         r_sd_cmd      <= SdInit;
         r_lcd_cmd     <= LcdInit;
         r_sd_blk_addr <= '0;
         r_stream_en   <= 1'b0;
         r_uart_ack    <= 1'b0;
         r_pic_idx     <= '0;
         r_blk_id      <= BASE_BLK;
         r_blk_offset  <= '0;
         r_req_incr    <= 1'b0;
         r_req_decr    <= 1'b0;
      end else begin
         r_boot      <= 1'b0;
         r_state     <= w_state_d;
         r_stream_en <= (w_state_d == StStream);
         r_uart_ack  <= (w_state_d == StIdxMod);
         if (w_sd_start) begin
            r_sd_cmd <= w_sd_code;
         end
         if (w_sd_start && (w_sd_code == SdBlkRd)) begin
            r_sd_blk_addr <= w_blk_addr;
         end
         if (w_lcd_start && !w_lcd_skip) begin
            r_lcd_cmd <= w_lcd_code;
         end
         case (r_state)
            StOfsRst: r_blk_offset <= '0;
            StCrc: begin
               if (w_both_done) begin
                  r_blk_offset <= w_off_inc[8:0];
               end
            end
            StWaitUart: begin
               if (w_req) begin
                  r_req_incr <= i_uart_incr;
                  r_req_decr <= i_uart_decr;
               end
            end
            StIdxMod: begin
               // Both requests together leave the index alone and redraw.
               if (r_req_incr && !r_req_decr) begin
                  if (r_pic_idx == IdxW'(N_PIC - 1)) begin
                     r_pic_idx <= '0;
                     r_blk_id  <= BASE_BLK;
                  end else begin
                     r_pic_idx <= r_pic_idx + 1'b1;
                     r_blk_id  <= r_blk_id + BLK_PER_PIC;
                  end
               end else if (r_req_decr && !r_req_incr) begin
                  if (r_pic_idx == '0) begin
                     r_pic_idx <= IdxW'(N_PIC - 1);
                     r_blk_id  <= LastBlk;
                  end else begin
                     r_pic_idx <= r_pic_idx - 1'b1;
                     r_blk_id  <= r_blk_id - BLK_PER_PIC;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sd_cmd      = r_sd_cmd;
   assign o_lcd_cmd     = r_lcd_cmd;
   assign o_sd_blk_addr = r_sd_blk_addr;
   assign o_stream_en   = r_stream_en;
   assign o_uart_ack    = r_uart_ack;
   assign o_pic_idx     = r_pic_idx;
   assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl: busy-counter peripheral models and a
// scoreboard of expected SD/LCD command pulses.
module tb_frame_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sd_cmd_valid, lcd_cmd_valid, stream_en, uart_ack;
   logic [1:0]  sd_cmd, lcd_cmd;
   logic [31:0] sd_blk_addr;
   logic        sd_busy, lcd_busy;
   logic        uart_incr = 1'b0, uart_decr = 1'b0;
   logic [3:0]  pic_idx;
   logic [6:0]  state_dbg;

   localparam logic [6:0] SInit = 7'b000_0001;
   localparam logic [6:0] SWait = 7'b010_0000;

   frame_seq_ctrl dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .o_sd_cmd_valid  (sd_cmd_valid),
      .o_sd_cmd        (sd_cmd),
      .o_sd_blk_addr   (sd_blk_addr),
      .i_sd_busy       (sd_busy),
      .o_lcd_cmd_valid (lcd_cmd_valid),
      .o_lcd_cmd       (lcd_cmd),
      .i_lcd_busy      (lcd_busy),
      .o_stream_en     (stream_en),
      .i_uart_incr     (uart_incr),
      .i_uart_decr     (uart_decr),
      .o_uart_ack      (uart_ack),
      .o_pic_idx       (pic_idx),
      .o_state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sd_len[4];
   int lcd_len[4];
   int sd_cnt, lcd_cnt;
   int blk_cnt = 0, crc_cnt = 0;
   int last_stream_cyc = 0, last_crc_cyc = 0;
   logic [33:0] sd_q[$];
   logic [1:0]  lcd_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral models: busy for len cycles starting the cycle after a command.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sd_cnt <= 0;
      else if (sd_cmd_valid) sd_cnt <= sd_len[sd_cmd];
      else if (sd_cnt > 0) sd_cnt <= sd_cnt - 1;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lcd_cnt <= 0;
      else if (lcd_cmd_valid) lcd_cnt <= lcd_len[lcd_cmd];
      else if (lcd_cnt > 0) lcd_cnt <= lcd_cnt - 1;
   end
   assign sd_busy  = (sd_cnt > 0);
   assign lcd_busy = (lcd_cnt > 0);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: pop and compare on every command pulse.
   always @(negedge clk) begin
      logic [33:0] got_sd;
      logic [33:0] exp_sd;
      logic [1:0]  exp_lcd;
      if (rst_n && sd_cmd_valid) begin
         got_sd = {sd_cmd, (sd_cmd == 2'd1) ? sd_blk_addr : 32'd0};
         checks++;
         assert (sd_q.size() > 0) else begin
            errors++;
            $error("FAIL sd_extra_pulse: got %h expected none", got_sd);
         end
         if (sd_q.size() > 0) begin
            exp_sd = sd_q.pop_front();
            checks++;
            assert (got_sd === exp_sd) else begin
               errors++;
               $error("FAIL sd_cmd: got %h expected %h", got_sd, exp_sd);
            end
         end
         if (sd_cmd == 2'd1) blk_cnt++;
         if (sd_cmd == 2'd2) last_stream_cyc = cyc;
         if (sd_cmd == 2'd3) begin
            crc_cnt++;
            last_crc_cyc = cyc;
         end
      end
      if (rst_n && lcd_cmd_valid) begin
         checks++;
         assert (lcd_q.size() > 0) else begin
            errors++;
            $error("FAIL lcd_extra_pulse: got %0d expected none", lcd_cmd);
         end
         if (lcd_q.size() > 0) begin
            exp_lcd = lcd_q.pop_front();
            checks++;
            assert (lcd_cmd === exp_lcd) else begin
               errors++;
               $error("FAIL lcd_cmd: got %0d expected %0d", lcd_cmd, exp_lcd);
            end
         end
      end
   end

   task automatic push_frame(input logic [31:0] base, input bit with_init);
      if (with_init) begin
         sd_q.push_back({2'd0, 32'd0});
         lcd_q.push_back(2'd0);
      end
      lcd_q.push_back(2'd1);
      for (int k = 0; k < 300; k++) begin
         sd_q.push_back({2'd1, base + 32'(k)});
         sd_q.push_back({2'd2, 32'd0});
         sd_q.push_back({2'd3, 32'd0});
         lcd_q.push_back(2'd2);
      end
   endtask

   task automatic set_len(input int n);
      for (int i = 0; i < 4; i++) begin
         sd_len[i]  = n;
         lcd_len[i] = n;
      end
   endtask

   task automatic finish_frame(input logic [3:0] exp_idx, input int b0, input int c0);
      int n = 0;
      while (state_dbg !== SWait && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("park_reached", state_dbg, SWait);
      chk("blk_rd_count", blk_cnt - b0, 300);
      chk("crc_count", crc_cnt - c0, 300);
      chk("sd_queue_drained", sd_q.size(), 0);
      chk("lcd_queue_drained", lcd_q.size(), 0);
      chk("frame_pic_idx", pic_idx, exp_idx);
      repeat (20) @(negedge clk);
      chk("still_parked", state_dbg, SWait);
      chk("stream_en_parked", stream_en, 0);
   endtask

   task automatic uart_req(input logic inc, input logic dec, input logic [3:0] exp_idx);
      int n = 0;
      uart_incr = inc;
      uart_decr = dec;
      while (uart_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("uart_ack_seen", uart_ack, 1);
      uart_incr = 1'b0;
      uart_decr = 1'b0;
      @(negedge clk);
      chk("uart_ack_one_cycle", uart_ack, 0);
      chk("uart_pic_idx", pic_idx, exp_idx);
   endtask

   initial begin
      int b0, c0, n;
      set_len(10);
      push_frame(32'd0, 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_state", state_dbg, SInit);
      chk("rst_sd_valid", sd_cmd_valid, 0);
      chk("rst_lcd_valid", lcd_cmd_valid, 0);
      chk("rst_cmds", {sd_cmd, lcd_cmd}, 0);
      chk("rst_addr", sd_blk_addr, 0);
      chk("rst_stream_en", stream_en, 0);
      chk("rst_ack_idx", {uart_ack, pic_idx}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_pulse_pair", {sd_cmd_valid, lcd_cmd_valid}, 2'b11);

      // Full frame with 10-cycle busy on every command.
      finish_frame(4'd0, 0, 0);

      // Decrement wrap; first block STREAM skewed (SD 50, LCD 5).
      set_len(1);
      sd_len[2] = 50;
      lcd_len[2] = 5;
      b0 = blk_cnt;
      c0 = crc_cnt;
      push_frame(32'd4500, 1'b0);
      uart_req(1'b0, 1'b1, 4'd15);
      n = 0;
      while (crc_cnt == c0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("skew_crc_seen", crc_cnt - c0, 1);
      chk("skew_exit_latency", last_crc_cyc - last_stream_cyc, 52);
      set_len(1);
      finish_frame(4'd15, b0, c0);

      // Increment wrap 15 -> 0, then step up to picture 3.
      b0 = blk_cnt;
      c0 = crc_cnt;
      push_frame(32'd0, 1'b0);
      uart_req(1'b1, 1'b0, 4'd0);
      finish_frame(4'd0, b0, c0);
      for (int i = 1; i <= 3; i++) begin
         b0 = blk_cnt;
         c0 = crc_cnt;
         push_frame(32'(300 * i), 1'b0);
         uart_req(1'b1, 1'b0, 4'(i));
         finish_frame(4'(i), b0, c0);
      end

      // Both requests: redraw picture 3.
      b0 = blk_cnt;
      c0 = crc_cnt;
      push_frame(32'd900, 1'b0);
      uart_req(1'b1, 1'b1, 4'd3);
      finish_frame(4'd3, b0, c0);

      // Reset during STREAM of block 150 of picture 4.
      b0 = blk_cnt;
      push_frame(32'd1200, 1'b0);
      uart_req(1'b1, 1'b0, 4'd4);
      n = 0;
      while (!((blk_cnt - b0) == 151 && stream_en === 1'b1) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_blk150_stream", stream_en, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_stream_en", stream_en, 0);
      chk("abort_state", state_dbg, SInit);
      chk("abort_pic_idx", pic_idx, 0);
      sd_q.delete();
      lcd_q.delete();
      push_frame(32'd0, 1'b1);
      b0 = blk_cnt;
      c0 = crc_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reinit_pulse_pair", {sd_cmd_valid, lcd_cmd_valid, sd_cmd, lcd_cmd}, 6'b110000);
      finish_frame(4'd0, b0, c0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
